pixel_scheduler: RTL and testbench
==================================

// Module: pixel_scheduler
// PURPOSE
//  Frame sequencer for the pixel-to-complex mapping stage. Raster-scans a
//  SCREEN_W x SCREEN_H frame and drives pixel_x/pixel_y plus the stage enable.
//  Holds the x/y pan offsets constant for a whole frame. Tracks the stage's
//  1-cycle latency with valid/ready so the downstream engines can apply
//  backpressure.
// PARAMETERS
//  PIXEL_DATA_WIDTH   10   width of the pixel coordinates
//  ENGINE_DATA_WIDTH  25   width of the signed Q4.20 offsets
//  SCREEN_W           640  pixels per line; must be >= 1 and <= 2**PIXEL_DATA_WIDTH
//  SCREEN_H           480  lines per frame; must be >= 1 and <= 2**PIXEL_DATA_WIDTH
// PORTS
//  clk          in   1    single clock; all logic is on the rising edge
//  reset        in   1    synchronous reset, active-low (0 = reset)
//  start        in   1    request one frame; sampled only in IDLE
//  continuous   in   1    1 = restart automatically after each frame
//  x_offset_in  in   EDW  signed pan offset, real axis
//  y_offset_in  in   EDW  signed pan offset, imaginary axis
//  out_ready    in   1    downstream accepts the current mapped pixel
//  map_en       out  1    enable to the mapping stage (combinational)
//  pixel_x      out  PDW  column presented to the mapping stage
//  pixel_y      out  PDW  row presented to the mapping stage
//  x_offset     out  EDW  latched offset to the mapping stage
//  y_offset     out  EDW  latched offset to the mapping stage
//  out_valid    out  1    the mapping-stage output holds a valid pixel
//  out_sof      out  1    the valid pixel is (0,0); qualified by out_valid
//  out_eol      out  1    the valid pixel is the last in its line
//  out_eof      out  1    the valid pixel is the last in the frame
//  busy         out  1    state != IDLE
//  frame_done   out  1    1-cycle pulse, the cycle after the last eof handshake
// BEHAVIOUR
//  Reset values (reset==0):
//   - state=IDLE; pixel_x=pixel_y=0; x_offset=y_offset=0
//   - out_valid/sof/eol/eof=0; frame_done=0
//   - Reset mid-frame drops in-flight pixels; no frame_done is produced.
//  Pipeline advance:
//   - adv = !out_valid || out_ready; map_en = adv. Holds even in IDLE.
//   - On adv: out_valid <= (state==RUN).
//   - On adv: sof/eol/eof <= the flags of the (pixel_x,pixel_y) being issued
//     (all 0 when not in RUN).
//   - out_valid with !out_ready: map_en=0; pixel_x/y, flags and out_valid
//     hold stable.
//  FSM:
//   - IDLE -> RUN on start: latch offsets from the _in ports; x=y=0.
//   - RUN: each adv issues the current (x,y).
//       x==SCREEN_W-1: x<=0 and y<=y+1, else x<=x+1.
//       Issuing (W-1,H-1) -> FLUSH; the counters keep that value.
//   - FLUSH: wait for the handshake out_valid && out_ready && out_eof.
//     In that cycle adv issues nothing, so out_valid falls next cycle.
//       continuous=1: relatch offsets, x=y=0, go to RUN.
//       continuous=0: go to IDLE.
//     frame_done is registered high for the one following cycle.
//  Timing:
//   - The offsets change only on the IDLE->RUN or FLUSH->RUN transition.
//     Changes to the _in ports mid-frame have no effect.
//   - start while busy is ignored. continuous is sampled only in the FLUSH
//     handshake cycle.
//   - Latency with out_ready=1: start at cycle 0 -> map_en+(0,0) at cycle 1
//     -> out_valid at cycle 2. The last pixel is valid at cycle W*H+1.
//     frame_done is at cycle W*H+2. Throughput is 1 pixel/clk.
//   - W=1 or H=1: sof, eol and eof may be set together; W=H=1 is legal.
//  Widths:
//   - The counters are PIXEL_DATA_WIDTH bits and never wrap past W-1/H-1.
//   - Line/frame end is detected by compare, not by overflow.
// TESTING (W=4, H=3 unless stated)
//  1. reset=0 for 2 clk with start=1 -> all outputs 0, busy=0; none rise
//     until the cycle after reset=1.
//  2. start pulse, out_ready=1, continuous=0 -> 12 valid beats in raster
//     order (0,0)..(3,2).
//     sof on beat 1; eol on beats 4, 8, 12; eof on beat 12.
//     frame_done at cycle 14; busy drops at cycle 14.
//  3. out_ready toggled 1010... -> the same 12 beats in order, each held
//     until accepted. No duplicate or skipped beat; map_en=0 exactly while
//     stalled.
//  4. x_offset_in=0x0100000, change to 0x0200000 mid-frame, continuous=1
//     -> frame 1 uses 0x0100000 and frame 2 uses 0x0200000.
//     No idle beat between the frames.
//  5. start asserted during RUN and during FLUSH -> ignored; a single frame
//     completes.
//  6. reset=0 at beat 6 -> out_valid=0 and state=IDLE next cycle, no
//     frame_done; a new start restarts at (0,0). Repeat with W=H=1: one beat
//     with sof=eol=eof=1.

Source files
------------

// File: rtl/pixel_scheduler.sv
// Frame sequencer for the pixel-to-complex mapping stage: raster-scans one frame,
// holds the pan offsets per frame and tracks the stage's 1-cycle latency with valid/ready.
module pixel_scheduler #(
  parameter int PIXEL_DATA_WIDTH  = 10,
  parameter int ENGINE_DATA_WIDTH = 25,
  parameter int SCREEN_W          = 640,
  parameter int SCREEN_H          = 480
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         continuous,
  input  logic [ENGINE_DATA_WIDTH-1:0] x_offset_in,
  input  logic [ENGINE_DATA_WIDTH-1:0] y_offset_in,
  input  logic                         out_ready,
  output logic                         map_en,
  output logic [PIXEL_DATA_WIDTH-1:0]  pixel_x,
  output logic [PIXEL_DATA_WIDTH-1:0]  pixel_y,
  output logic [ENGINE_DATA_WIDTH-1:0] x_offset,
  output logic [ENGINE_DATA_WIDTH-1:0] y_offset,
  output logic                         out_valid,
  output logic                         out_sof,
  output logic                         out_eol,
  output logic                         out_eof,
  output logic                         busy,
  output logic                         frame_done
);

  localparam logic [PIXEL_DATA_WIDTH-1:0] X_LAST = PIXEL_DATA_WIDTH'(SCREEN_W - 1);
  localparam logic [PIXEL_DATA_WIDTH-1:0] Y_LAST = PIXEL_DATA_WIDTH'(SCREEN_H - 1);

  typedef enum logic [1:0] {IDLE, RUN, FLUSH} state_t;

  state_t r_state, w_state_nxt;

  logic [PIXEL_DATA_WIDTH-1:0]  r_x, r_y;
  logic [ENGINE_DATA_WIDTH-1:0] r_xoff, r_yoff;
  logic r_valid, r_sof, r_eol, r_eof, r_done;

  logic w_adv, w_issue, w_load, w_x_last, w_y_last, w_last, w_hs_eof;

  assign w_adv    = !r_valid || out_ready;
  assign w_x_last = (r_x == X_LAST);
  assign w_y_last = (r_y == Y_LAST);
  assign w_last   = w_x_last && w_y_last;
  assign w_hs_eof = r_valid && out_ready && r_eof;
  assign w_issue  = (r_state == RUN) && w_adv;

  always_ff @(posedge clk) begin
    if (!reset) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: if (start) begin
        w_state_nxt = RUN;
        w_load      = 1'b1;
      end
      RUN: if (w_adv && w_last) w_state_nxt = FLUSH;
      FLUSH: if (w_hs_eof) begin
        // continuous is only looked at here, on the final eof handshake
        w_state_nxt = continuous ? RUN : IDLE;
        w_load      = continuous;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_x     <= '0;
      r_y     <= '0;
      r_xoff  <= '0;
      r_yoff  <= '0;
      r_valid <= 1'b0;
      r_sof   <= 1'b0;
      r_eol   <= 1'b0;
      r_eof   <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      if (w_adv) begin
        r_valid <= w_issue;
        r_sof   <= w_issue && (r_x == '0) && (r_y == '0);
        r_eol   <= w_issue && w_x_last;
        r_eof   <= w_issue && w_last;
      end
      if (w_load) begin
        r_x    <= '0;
        r_y    <= '0;
        r_xoff <= x_offset_in;
        r_yoff <= y_offset_in;
      end else if (w_issue && !w_last) begin
        // the final pixel leaves the counters parked at (W-1,H-1) through FLUSH
        if (w_x_last) begin
          r_x <= '0;
          r_y <= r_y + 1'b1;
        end else begin
          r_x <= r_x + 1'b1;
        end
      end
      r_done <= (r_state == FLUSH) && w_hs_eof;
    end
  end

  assign map_en     = w_adv;
  assign pixel_x    = r_x;
  assign pixel_y    = r_y;
  assign x_offset   = r_xoff;
  assign y_offset   = r_yoff;
  assign out_valid  = r_valid;
  assign out_sof    = r_sof;
  assign out_eol    = r_eol;
  assign out_eof    = r_eof;
  assign busy       = (r_state != IDLE);
  assign frame_done = r_done;

endmodule

// File: tb/tb_pixel_scheduler.sv
// Directed bench for pixel_scheduler: a 4x3 instance for raster/stall/offset/reset
// scenarios plus a 1x1 instance for the degenerate single-pixel frame.
module tb_pixel_scheduler;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b0, start = 1'b1, continuous = 1'b0, out_ready = 1'b1;
  logic [24:0] x_offset_in = '0, y_offset_in = '0;
  logic        map_en, out_valid, out_sof, out_eol, out_eof, busy, frame_done;
  logic [9:0]  pixel_x, pixel_y;
  logic [24:0] x_offset, y_offset;

  logic        reset1 = 1'b0, start1 = 1'b0;
  logic        map_en1, out_valid1, out_sof1, out_eol1, out_eof1, busy1, frame_done1;
  logic [9:0]  pixel_x1, pixel_y1;
  logic [24:0] x_offset1, y_offset1;

  pixel_scheduler #(.PIXEL_DATA_WIDTH(10), .ENGINE_DATA_WIDTH(25), .SCREEN_W(4), .SCREEN_H(3)) dut (
    .clk(clk), .reset(reset), .start(start), .continuous(continuous),
    .x_offset_in(x_offset_in), .y_offset_in(y_offset_in), .out_ready(out_ready),
    .map_en(map_en), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .x_offset(x_offset), .y_offset(y_offset), .out_valid(out_valid),
    .out_sof(out_sof), .out_eol(out_eol), .out_eof(out_eof),
    .busy(busy), .frame_done(frame_done));

  pixel_scheduler #(.PIXEL_DATA_WIDTH(10), .ENGINE_DATA_WIDTH(25), .SCREEN_W(1), .SCREEN_H(1)) dut1 (
    .clk(clk), .reset(reset1), .start(start1), .continuous(continuous),
    .x_offset_in(x_offset_in), .y_offset_in(y_offset_in), .out_ready(out_ready),
    .map_en(map_en1), .pixel_x(pixel_x1), .pixel_y(pixel_y1),
    .x_offset(x_offset1), .y_offset(y_offset1), .out_valid(out_valid1),
    .out_sof(out_sof1), .out_eol(out_eol1), .out_eof(out_eof1),
    .busy(busy1), .frame_done(frame_done1));

  int n_chk = 0, n_pass = 0;

  // Activity log of the 4x3 instance, filled one sample per clock
  int          cyc, n_iss, n_beat, fd_cnt, fd_cyc;
  logic [9:0]  iss_x [32], iss_y [32];
  logic        b_sof [32], b_eol [32], b_eof [32];
  logic [24:0] b_xoff [32], b_yoff [32];
  int          b_cyc [32];

  task automatic clr_log();
    cyc = -1; n_iss = 0; n_beat = 0; fd_cnt = 0; fd_cyc = -1;
  endtask

  // Drive inputs for the coming edge, then sample just after.
  task automatic run_cycle(input logic rdy, input logic st);
    @(negedge clk);
    out_ready = rdy;
    start     = st;
    #1;
    cyc++;
    if (map_en && busy && n_iss < 12) begin
      iss_x[n_iss] = pixel_x; iss_y[n_iss] = pixel_y; n_iss++;
    end
    if (out_valid && out_ready && n_beat < 32) begin
      b_sof[n_beat] = out_sof; b_eol[n_beat] = out_eol; b_eof[n_beat] = out_eof;
      b_xoff[n_beat] = x_offset; b_yoff[n_beat] = y_offset; b_cyc[n_beat] = cyc;
      n_beat++;
    end
    if (frame_done) begin fd_cnt++; fd_cyc = cyc; end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 2; k++) begin
      @(negedge clk); reset = 1'b0; reset1 = 1'b0; start = 1'b1; #1;
      n_chk++; if ({out_valid, out_sof, out_eol, out_eof, frame_done, busy} !== 6'b0)
        $display("FAIL reset_flags: got %b exp 000000", {out_valid, out_sof, out_eol, out_eof, frame_done, busy}); else n_pass++;
      n_chk++; if ({pixel_x, pixel_y, x_offset, y_offset} !== 70'b0)
        $display("FAIL reset_regs: got %h exp 0", {pixel_x, pixel_y, x_offset, y_offset}); else n_pass++;
    end
    @(negedge clk); reset = 1'b1; reset1 = 1'b1; #1;
    n_chk++; if (busy !== 1'b0) $display("FAIL reset_release_busy: got %b exp 0", busy); else n_pass++;
    @(negedge clk); start = 1'b0; #1;
    n_chk++; if (busy !== 1'b1) $display("FAIL reset_after_busy: got %b exp 1", busy); else n_pass++;
    @(negedge clk); reset = 1'b0;
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_frame();
    logic busy13, busy14;
    busy13 = 1'bx; busy14 = 1'bx;
    clr_log();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 40 && fd_cnt == 0; k++) begin
      run_cycle(1'b1, 1'b0);
      if (cyc == 13) busy13 = busy;
      if (cyc == 14) busy14 = busy;
    end
    n_chk++; if (n_iss !== 12) $display("FAIL frame_issues: got %0d exp 12", n_iss); else n_pass++;
    n_chk++; if (n_beat !== 12) $display("FAIL frame_beats: got %0d exp 12", n_beat); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_chk++; if (iss_x[i] !== 10'(i % 4) || iss_y[i] !== 10'(i / 4))
        $display("FAIL frame_order[%0d]: got (%0d,%0d) exp (%0d,%0d)", i, iss_x[i], iss_y[i], i % 4, i / 4); else n_pass++;
      n_chk++; if ({b_sof[i], b_eol[i], b_eof[i]} !== {i == 0, i % 4 == 3, i == 11})
        $display("FAIL frame_flags[%0d]: got %b exp %b", i, {b_sof[i], b_eol[i], b_eof[i]}, {i == 0, i % 4 == 3, i == 11}); else n_pass++;
    end
    n_chk++; if (b_cyc[0] !== 2) $display("FAIL frame_first_valid_cyc: got %0d exp 2", b_cyc[0]); else n_pass++;
    n_chk++; if (b_cyc[11] !== 13) $display("FAIL frame_last_valid_cyc: got %0d exp 13", b_cyc[11]); else n_pass++;
    n_chk++; if (fd_cyc !== 14) $display("FAIL frame_done_cyc: got %0d exp 14", fd_cyc); else n_pass++;
    n_chk++; if ({busy13, busy14} !== 2'b10) $display("FAIL frame_busy_13_14: got %b exp 10", {busy13, busy14}); else n_pass++;
    run_cycle(1'b1, 1'b0);
    n_chk++; if (frame_done !== 1'b0 || fd_cnt !== 1) $display("FAIL frame_done_pulse: got %b cnt %0d exp 0 cnt 1", frame_done, fd_cnt); else n_pass++;
  endtask

  task automatic test_stall();
    logic       p_stall;
    logic [9:0] p_x, p_y;
    logic [2:0] p_fl;
    p_stall = 1'b0; p_x = '0; p_y = '0; p_fl = '0;
    clr_log();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 80 && fd_cnt == 0; k++) begin
      run_cycle(k % 2 == 0, 1'b0);
      n_chk++; if (map_en !== !(out_valid && !out_ready))
        $display("FAIL stall_map_en c%0d: got %b exp %b", cyc, map_en, !(out_valid && !out_ready)); else n_pass++;
      if (p_stall) begin
        n_chk++; if ({out_valid, pixel_x, pixel_y, out_sof, out_eol, out_eof} !== {1'b1, p_x, p_y, p_fl})
          $display("FAIL stall_hold c%0d: got %h exp %h", cyc, {out_valid, pixel_x, pixel_y, out_sof, out_eol, out_eof}, {1'b1, p_x, p_y, p_fl}); else n_pass++;
      end
      p_stall = out_valid && !out_ready;
      p_x = pixel_x; p_y = pixel_y; p_fl = {out_sof, out_eol, out_eof};
    end
    n_chk++; if (n_beat !== 12 || n_iss !== 12) $display("FAIL stall_counts: got %0d/%0d exp 12/12", n_beat, n_iss); else n_pass++;
    for (int i = 0; i < 12; i++) begin
      n_chk++; if ({iss_x[i], iss_y[i], b_sof[i], b_eol[i], b_eof[i]} !== {10'(i % 4), 10'(i / 4), i == 0, i % 4 == 3, i == 11})
        $display("FAIL stall_beat[%0d]: got (%0d,%0d) %b", i, iss_x[i], iss_y[i], {b_sof[i], b_eol[i], b_eof[i]}); else n_pass++;
    end
    n_chk++; if (fd_cnt !== 1) $display("FAIL stall_done: got %0d exp 1", fd_cnt); else n_pass++;
  endtask

  task automatic test_offsets();
    logic busy_at_done;
    busy_at_done = 1'b0;
    x_offset_in = 25'h0100000; y_offset_in = 25'h1F00000; continuous = 1'b1;
    clr_log();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 80 && fd_cnt < 2; k++) begin
      if (k == 5) begin x_offset_in = 25'h0200000; y_offset_in = 25'h0080000; end
      run_cycle(1'b1, 1'b0);
      if (frame_done && fd_cnt == 1) begin busy_at_done = busy; continuous = 1'b0; end
    end
    n_chk++; if (n_beat !== 24 || fd_cnt !== 2) $display("FAIL offs_counts: got %0d beats %0d done exp 24 2", n_beat, fd_cnt); else n_pass++;
    for (int i = 0; i < 24; i++) begin
      n_chk++; if ({b_xoff[i], b_yoff[i]} !== (i < 12 ? {25'h0100000, 25'h1F00000} : {25'h0200000, 25'h0080000}))
        $display("FAIL offs_beat[%0d]: got %h %h", i, b_xoff[i], b_yoff[i]); else n_pass++;
    end
    n_chk++; if ({b_sof[12], b_eof[23]} !== 2'b11) $display("FAIL offs_frame2_flags: got %b exp 11", {b_sof[12], b_eof[23]}); else n_pass++;
    n_chk++; if (busy_at_done !== 1'b1) $display("FAIL offs_no_idle: got busy %b exp 1", busy_at_done); else n_pass++;
    n_chk++; if (b_cyc[12] !== 15) $display("FAIL offs_frame2_first_cyc: got %0d exp 15", b_cyc[12]); else n_pass++;
    run_cycle(1'b1, 1'b0);
    n_chk++; if (busy !== 1'b0) $display("FAIL offs_stop: got busy %b exp 0", busy); else n_pass++;
  endtask

  task automatic test_start_busy();
    int   n_stall, n_sofs;
    logic st;
    n_stall = 0; st = 1'b1;
    clr_log();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 80 && fd_cnt == 0; k++) begin
      if (n_beat == 11 && n_stall < 3) begin n_stall++; run_cycle(1'b0, st); end
      else run_cycle(1'b1, st);
      if (n_beat == 12) begin st = 1'b0; start = 1'b0; end
    end
    for (int k = 0; k < 3; k++) run_cycle(1'b1, 1'b0);
    n_sofs = 0;
    for (int i = 0; i < n_beat && i < 32; i++) n_sofs += int'(b_sof[i]);
    n_chk++; if (n_beat !== 12 || n_sofs !== 1) $display("FAIL start_busy_beats: got %0d beats %0d sof exp 12 1", n_beat, n_sofs); else n_pass++;
    n_chk++; if (fd_cnt !== 1 || busy !== 1'b0) $display("FAIL start_busy_single: got %0d done busy %b exp 1 0", fd_cnt, busy); else n_pass++;
    n_chk++; if (b_eof[11] !== 1'b1) $display("FAIL start_busy_eof: got %b exp 1", b_eof[11]); else n_pass++;
  endtask

  task automatic test_reset_mid();
    clr_log();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 40 && n_beat < 6; k++) run_cycle(1'b1, 1'b0);
    reset = 1'b0;
    run_cycle(1'b1, 1'b0);
    reset = 1'b1;
    n_chk++; if ({out_valid, busy} !== 2'b00) $display("FAIL rst_mid_state: got %b exp 00", {out_valid, busy}); else n_pass++;
    for (int k = 0; k < 5; k++) run_cycle(1'b1, 1'b0);
    n_chk++; if (fd_cnt !== 0 || n_beat !== 6) $display("FAIL rst_mid_no_done: got %0d done %0d beats exp 0 6", fd_cnt, n_beat); else n_pass++;
    clr_log();
    run_cycle(1'b1, 1'b1);
    for (int k = 0; k < 40 && fd_cnt == 0; k++) run_cycle(1'b1, 1'b0);
    n_chk++; if ({iss_x[0], iss_y[0], b_sof[0]} !== {20'd0, 1'b1}) $display("FAIL rst_mid_restart: got (%0d,%0d) sof %b", iss_x[0], iss_y[0], b_sof[0]); else n_pass++;
    n_chk++; if (n_beat !== 12 || fd_cnt !== 1) $display("FAIL rst_mid_refraame: got %0d beats %0d done exp 12 1", n_beat, fd_cnt); else n_pass++;
  endtask

  task automatic test_single_pixel();
    @(negedge clk); out_ready = 1'b1; start1 = 1'b1; #1;
    @(negedge clk); start1 = 1'b0; #1;
    n_chk++; if ({map_en1, busy1, pixel_x1, pixel_y1, out_valid1} !== {2'b11, 20'd0, 1'b0})
      $display("FAIL one_issue: got %b %b (%0d,%0d) %b", map_en1, busy1, pixel_x1, pixel_y1, out_valid1); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if ({out_valid1, out_sof1, out_eol1, out_eof1, frame_done1} !== 5'b11110)
      $display("FAIL one_beat: got %b exp 11110", {out_valid1, out_sof1, out_eol1, out_eof1, frame_done1}); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if ({frame_done1, busy1, out_valid1} !== 3'b100) $display("FAIL one_done: got %b exp 100", {frame_done1, busy1, out_valid1}); else n_pass++;
    @(negedge clk); #1;
    n_chk++; if (frame_done1 !== 1'b0) $display("FAIL one_done_pulse: got %b exp 0", frame_done1); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_frame();
    test_stall();
    test_offsets();
    test_start_busy();
    test_reset_mid();
    test_single_pixel();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
